// File: rtl/display_timing_counters.sv
// Pixel/line/buffer-0 address counters and double-buffered timing limits for the display controller.
// Optional status block (FrameCount, OvfFlags) is built only when DISP_TIMING_STATUS_EN is defined.
module display_timing_counters #(
   parameter int CNT_W      = 4,
   parameter int ADDR_W     = 6,
   parameter int ADDR_DEPTH = 48,
   parameter int AIP_RST    = 4,
   parameter int AIL_RST    = 3,
   parameter int VB_RST     = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              CSDisplay,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_sel,
   input  logic [CNT_W-1:0]  cfg_data,
   input  logic              IncPx,
   input  logic              ResetPx,
   input  logic              IncLine,
   input  logic              ResetLine,
   input  logic              IncAddr0,
   input  logic              ResetAddr0,
   output logic [CNT_W-1:0]  PxOut,
   output logic [CNT_W-1:0]  LineOut,
   output logic [CNT_W-1:0]  AIPOut,
   output logic [CNT_W-1:0]  AILOut,
   output logic [CNT_W-1:0]  VBOut,
   output logic [ADDR_W-1:0] Addr0,
   output logic              FrameDone,
   output logic              CfgErr,
   output logic [7:0]        FrameCount,
   output logic [2:0]        OvfFlags
);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_DEPTH - 1);

   logic [CNT_W-1:0]  px_q, px_d, line_q, line_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  aip_q, aip_d, ail_q, ail_d, vb_q, vb_d;
   logic [CNT_W-1:0]  aip_sh_q, aip_sh_d, ail_sh_q, ail_sh_d, vb_sh_q, vb_sh_d;
   logic              frame_done_q, frame_done_d;
   logic              cfg_err_q, cfg_err_d;
   logic              rl_prev_q, rl_prev_d;
   logic              rl_rise, commit, wr_legal;
   logic              px_sat_hit, line_sat_hit, addr_wrap_hit;

   always_comb begin
      rl_rise       = ResetLine & ~rl_prev_q;
      commit        = ~CSDisplay | rl_rise;
      rl_prev_d     = ResetLine;
      frame_done_d  = CSDisplay & rl_rise;
      px_sat_hit    = CSDisplay & ~ResetPx & IncPx & (px_q == CNT_MAX);
      line_sat_hit  = CSDisplay & ~ResetLine & IncLine & (line_q == CNT_MAX);
      addr_wrap_hit = CSDisplay & ~ResetAddr0 & IncAddr0 & (addr_q == ADDR_LAST);

      px_d   = px_q;
      line_d = line_q;
      addr_d = addr_q;
      if (CSDisplay) begin
         if (ResetPx)                         px_d = '0;
         else if (IncPx && px_q != CNT_MAX)   px_d = px_q + 1'b1;
         if (ResetLine)                       line_d = '0;
         else if (IncLine && line_q != CNT_MAX) line_d = line_q + 1'b1;
         if (ResetAddr0)                      addr_d = '0;
         else if (IncAddr0)                   addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
      end

      // VB legality is judged against the AIL shadow as it stood before this edge.
      wr_legal = 1'b0;
      if (cfg_we && cfg_data != '0) begin
         case (cfg_sel)
            2'd0, 2'd1: wr_legal = 1'b1;
            2'd2:       wr_legal = (cfg_data >= ail_sh_q);
            default:    wr_legal = 1'b0;
         endcase
      end
      cfg_err_d = cfg_err_q | (cfg_we & ~wr_legal);

      aip_sh_d = aip_sh_q;
      ail_sh_d = ail_sh_q;
      vb_sh_d  = vb_sh_q;
      if (wr_legal) begin
         case (cfg_sel)
            2'd0:    aip_sh_d = cfg_data;
            2'd1:    ail_sh_d = cfg_data;
            default: vb_sh_d  = cfg_data;
         endcase
      end

      // Loading from the next-shadow values gives write-through on a commit edge.
      aip_d = aip_q;
      ail_d = ail_q;
      vb_d  = vb_q;
      if (commit) begin
         aip_d = aip_sh_d;
         ail_d = ail_sh_d;
         vb_d  = vb_sh_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         px_q         <= '0;
         line_q       <= '0;
         addr_q       <= '0;
         aip_q        <= CNT_W'(AIP_RST);
         ail_q        <= CNT_W'(AIL_RST);
         vb_q         <= CNT_W'(VB_RST);
         aip_sh_q     <= CNT_W'(AIP_RST);
         ail_sh_q     <= CNT_W'(AIL_RST);
         vb_sh_q      <= CNT_W'(VB_RST);
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         rl_prev_q    <= 1'b0;
      end else begin
         px_q         <= px_d;
         line_q       <= line_d;
         addr_q       <= addr_d;
         aip_q        <= aip_d;
         ail_q        <= ail_d;
         vb_q         <= vb_d;
         aip_sh_q     <= aip_sh_d;
         ail_sh_q     <= ail_sh_d;
         vb_sh_q      <= vb_sh_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
         rl_prev_q    <= rl_prev_d;
      end
   end

`ifdef DISP_TIMING_STATUS_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [2:0] ovf_q, ovf_d;

   always_comb begin
      frame_cnt_d = frame_done_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
      ovf_d       = ovf_q | {addr_wrap_hit, line_sat_hit, px_sat_hit};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_cnt_q <= '0;
         ovf_q       <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign FrameCount = frame_cnt_q;
   assign OvfFlags   = ovf_q;
`else
   logic unused_status;
   assign unused_status = px_sat_hit ^ line_sat_hit ^ addr_wrap_hit;
   assign FrameCount    = '0;
   assign OvfFlags      = '0;
`endif

   assign PxOut     = px_q;
   assign LineOut   = line_q;
   assign Addr0     = addr_q;
   assign AIPOut    = aip_q;
   assign AILOut    = ail_q;
   assign VBOut     = vb_q;
   assign FrameDone = frame_done_q;
   assign CfgErr    = cfg_err_q;

endmodule
